sp: RTL and testbench
=====================

// Module: sp
// PURPOSE
//  Audio path: PDM MEMS microphone -> decimator -> 5-tap FIR -> PWM amplifier drive.
//  Generates the mic clock, turns 1-bit PDM into 17-bit signed PCM and filters it
//  through a 5-stage x/y/z datapath. The FIR output sets the duty cycle of ampPWM.
//  Top-level leaf; x, y, z are unpacked arrays [0:4] kept visible for bench probing.
// PARAMETERS
//  MIC_DIV     40   clk cycles per micClk period (even; micClk high for MIC_DIV/2)
//  DEC         16   PDM bits per PCM sample
//  PWM_PERIOD  320  clk cycles per PWM period
// PORTS
//  One clock; reset is asynchronous and active-low.
//  clk       in   1  system clock (100 MHz)
//  rst_n     in   1  asynchronous active-low reset
//  micClk    out  1  PDM mic clock, clk/MIC_DIV, 50% duty
//  micData   in   1  PDM data from mic
//  micLRSel  out  1  mic channel select, constant 0 (left)
//  ampPWM    out  1  PWM audio output
//  ampSD     out  1  amplifier enable (1 = on)
// BEHAVIOUR
//  Reset (rst_n=0): micClk=0, ampPWM=0, ampSD=0; divider, bit/ones counters, x, y, z,
//   PWM counter and duty latch all 0. All state is registered; reset acts immediately.
//  ampSD is a register set to 1 on the first clk edge after rst_n deasserts.
//  micClk: divider counts 0..MIC_DIV-1; micClk=1 for counts 0..MIC_DIV/2-1.
//  micData is sampled on the clk edge ending the high phase (count MIC_DIV/2-1);
//   the mic changes data just after micClk rises, so it is stable by then.
//  Decimator: counts ones over DEC sampled bits. After the DEC-th bit,
//   sample = 2*ones - DEC (17-bit signed, range -DEC..+DEC); counters clear.
//  x stage (on sample strobe): x[0]<=sample; x[k]<=x[k-1], k=1..4. 17-bit signed.
//  y stage (1 clk after x updates): y[k] = x[k] <<< s[k], s={0,1,2,1,0}. 17-bit signed.
//  z stage (1 clk after y): z[0]=sext20(y[0]); z[k]=z[k-1]+sext20(y[k]). 20-bit signed.
//   z[4] is the filter output, gain 10; |z[4]| <= 160 at DEC=16, so no overflow.
//  Latency: last PDM bit of a sample -> z[4] valid = 3 clk.
//  PWM: counter cnt runs 0..PWM_PERIOD-1 and wraps. At wrap, duty <= z[4] + PWM_PERIOD/2,
//   clamped to 0..PWM_PERIOD. ampPWM = (cnt < duty), registered.
//   duty=0 -> always low; duty=PWM_PERIOD -> always high.
//  Reset mid-stream discards the partial PDM sample; decimation restarts at bit 0.
// TESTING
//  1 Reset: hold rst_n=0 for 10 clk -> micClk=0, ampSD=0, ampPWM=0, all x/y/z = 0.
//  2 micClk: after reset, micClk period 40 clk, high 20 clk; micLRSel=0; ampSD=1.
//  3 micData toggles on every micClk rise for 64 bits -> each sample 0;
//    x,y,z stay 0; ampPWM 160 clk high / 160 clk low per period.
//  4 micData=1 constant -> sample=+16; after 5 samples z[4]=160, z[0]=16,
//    bit 16 of x/y and bit 19 of z = 0; ampPWM stays high after the next PWM wrap.
//  5 micData=0 constant -> sample=-16; sign bits x[k][16], y[k][16], z[k][19] = 1;
//    z[4]=-160; ampPWM stays low.
//  6 One all-ones sample, then alternating bits -> z[4] steps through 16,32,64,32,16
//    (one step per sample) and then returns to 0; rst_n pulse mid-sample clears all state.

Source files
------------

// File: rtl/sp.sv
// PDM mic capture -> 16:1 decimator -> 5-tap FIR (1,2,4,2,1) -> PWM amplifier drive.
// Latency: last PDM bit -> z[4] in 3 clk; duty follows z[4] at the next PWM wrap. No backpressure.
module sp #(
  parameter int MIC_DIV    = 40,
  parameter int DEC        = 16,
  parameter int PWM_PERIOD = 320
) (
  input  logic clk,
  input  logic rst_n,
  output logic micClk,
  input  logic micData,
  output logic micLRSel,
  output logic ampPWM,
  output logic ampSD
);
  localparam int DW = $clog2(MIC_DIV);
  localparam int BW = $clog2(DEC);
  localparam int OW = $clog2(DEC + 1);
  localparam int PW = $clog2(PWM_PERIOD + 1);

  logic [DW-1:0]        r_div;
  logic [DW-1:0]        w_div_nxt;
  logic                 r_mic_clk;
  logic                 r_amp_sd;
  logic                 w_tap;
  logic [BW-1:0]        r_bit_cnt;
  logic [OW-1:0]        r_ones;
  logic [OW-1:0]        w_ones_nxt;
  logic signed [16:0]   w_smp;
  logic signed [16:0]   r_smp;
  logic                 r_stb;
  logic signed [16:0]   x [0:4];
  logic signed [16:0]   y [0:4];
  logic signed [19:0]   z [0:4];
  logic signed [19:0]   w_e [0:4];
  logic signed [20:0]   w_duty_raw;
  logic [PW-1:0]        w_duty;
  logic [PW-1:0]        r_cnt;
  logic [PW-1:0]        r_duty;
  logic                 r_pwm;

  assign w_div_nxt  = (r_div == DW'(MIC_DIV - 1)) ? '0 : r_div + DW'(1);
  // Mic drives data just after micClk rises, so sample at the end of the high phase.
  assign w_tap      = (r_div == DW'(MIC_DIV / 2 - 1));
  assign w_ones_nxt = r_ones + OW'(micData);
  assign w_smp      = 17'({w_ones_nxt, 1'b0}) - 17'(DEC);

  assign micClk   = r_mic_clk;
  assign micLRSel = 1'b0;
  assign ampSD    = r_amp_sd;
  assign ampPWM   = r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_mic_clk <= 1'b0;
      r_amp_sd  <= 1'b0;
    end else begin
      r_div     <= w_div_nxt;
      r_mic_clk <= (w_div_nxt < DW'(MIC_DIV / 2));
      r_amp_sd  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_ones    <= '0;
      r_smp     <= '0;
      r_stb     <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (w_tap) begin
        if (r_bit_cnt == BW'(DEC - 1)) begin
          r_bit_cnt <= '0;
          r_ones    <= '0;
          r_smp     <= w_smp;
          r_stb     <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
          r_ones    <= w_ones_nxt;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      w_e[k] = 20'(y[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) begin
        x[k] <= '0;
        y[k] <= '0;
        z[k] <= '0;
      end
    end else begin
      if (r_stb) begin
        x[0] <= r_smp;
        for (int k = 1; k < 5; k++) begin
          x[k] <= x[k-1];
        end
      end
      y[0] <= x[0];
      y[1] <= x[1] <<< 1;
      y[2] <= x[2] <<< 2;
      y[3] <= x[3] <<< 1;
      y[4] <= x[4];
      // Running sums: z[4] is the full filter output with gain 10.
      z[0] <= w_e[0];
      z[1] <= w_e[0] + w_e[1];
      z[2] <= w_e[0] + w_e[1] + w_e[2];
      z[3] <= w_e[0] + w_e[1] + w_e[2] + w_e[3];
      z[4] <= w_e[0] + w_e[1] + w_e[2] + w_e[3] + w_e[4];
    end
  end

  assign w_duty_raw = 21'(z[4]) + 21'(PWM_PERIOD / 2);

  always_comb begin
    w_duty = '0;
    if (w_duty_raw < 21'sd0) begin
      w_duty = '0;
    end else if (w_duty_raw > 21'(PWM_PERIOD)) begin
      w_duty = PW'(PWM_PERIOD);
    end else begin
      w_duty = w_duty_raw[PW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      if (r_cnt == PW'(PWM_PERIOD - 1)) begin
        r_cnt  <= '0;
        r_duty <= w_duty;
      end else begin
        r_cnt <= r_cnt + PW'(1);
      end
      r_pwm <= (r_cnt < r_duty);
    end
  end
endmodule

// File: tb/tb_sp.sv
// Bench for sp: directed audio-path scenarios plus random PDM samples against a sample-level model.
module tb_sp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic micData = 1'b0;
  logic micClk, micLRSel, ampPWM, ampSD;

  int checks = 0;
  int failures = 0;

  // Reference model: PDM bits -> sample history, FIR taps 1,2,4,2,1.
  int m_ones = 0;
  int m_nbits = 0;
  int m_hist [5];
  localparam int MULT [5] = '{1, 2, 4, 2, 1};

  always #5 clk = ~clk;

  sp dut (
    .clk(clk), .rst_n(rst_n), .micClk(micClk), .micData(micData),
    .micLRSel(micLRSel), .ampPWM(ampPWM), .ampSD(ampSD)
  );

  // The mic bit is taken at the end of each micClk high phase.
  always @(negedge micClk or negedge rst_n) begin
    if (!rst_n) begin
      m_ones = 0;
      m_nbits = 0;
      for (int k = 0; k < 5; k++) m_hist[k] = 0;
    end else begin
      m_ones += int'(micData);
      m_nbits++;
      if (m_nbits == 16) begin
        for (int k = 4; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = 2 * m_ones - 16;
        m_ones = 0;
        m_nbits = 0;
      end
    end
  end

  function automatic int exp_y(input int k);
    return m_hist[k] * MULT[k];
  endfunction

  function automatic int exp_z(input int k);
    int s = 0;
    for (int j = 0; j <= k; j++) s += exp_y(j);
    return s;
  endfunction

  function automatic int exp_duty();
    int d = exp_z(4) + 160;
    if (d < 0) d = 0;
    if (d > 320) d = 320;
    return d;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s x%0d", tag, k), dut.x[k], m_hist[k]);
      chk($sformatf("%s y%0d", tag, k), dut.y[k], exp_y(k));
      chk($sformatf("%s z%0d", tag, k), dut.z[k], exp_z(k));
    end
  endtask

  task automatic check_model(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check_now(tag);
  endtask

  task automatic wait_mic(input logic lvl, output bit ok);
    logic prev;
    ok = 1'b0;
    prev = micClk;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (micClk === lvl && prev !== lvl) begin
        ok = 1'b1;
        break;
      end
      prev = micClk;
    end
  endtask

  task automatic send_bit(input logic b);
    bit ok1, ok2;
    wait_mic(1'b1, ok1);
    micData = b;
    wait_mic(1'b0, ok2);
    if (!(ok1 && ok2)) chk("mic_edge_timeout", 0, 1);
  endtask

  task automatic send_sample(input logic [15:0] bits, input string tag);
    for (int i = 0; i < 16; i++) send_bit(bits[i]);
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    micData = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic measure_pwm(output int hi);
    repeat (340) @(posedge clk);
    hi = 0;
    repeat (320) begin
      @(posedge clk);
      #1;
      hi += int'(ampPWM);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, nh, nl;
    bit ok;
    logic [15:0] bits;
    int unsigned a, b;
    int z4_tab [6] = '{16, 32, 64, 32, 16, 0};

    // Reset state
    repeat (10) @(posedge clk);
    #1;
    chk("rst micClk", micClk, 0);
    chk("rst ampSD", ampSD, 0);
    chk("rst ampPWM", ampPWM, 0);
    check_now("rst");
    rst_n = 1'b1;

    // micClk shape, LR select, amp enable
    @(posedge clk);
    #1;
    chk("ampSD on", ampSD, 1);
    chk("micLRSel", micLRSel, 0);
    wait_mic(1'b0, ok);
    wait_mic(1'b1, ok);
    nh = 0;
    while (micClk === 1'b1 && nh < 100) begin @(posedge clk); #1; nh++; end
    nl = 0;
    while (micClk === 1'b0 && nl < 100) begin @(posedge clk); #1; nl++; end
    chk("micClk high", nh, 20);
    chk("micClk period", nh + nl, 40);

    // Toggling PDM -> zero samples, 50% PWM
    do_reset();
    fork
      for (int s = 0; s < 4; s++) begin
        for (int i = 0; i < 16; i++) send_bit(logic'(i % 2));
        check_model("toggle");
        chk("toggle z4", dut.z[4], 0);
      end
      begin
        measure_pwm(hi);
        chk("pwm half", hi, 160);
      end
    join

    // All ones -> +16 samples, full-scale positive
    do_reset();
    for (int s = 0; s < 6; s++) send_sample(16'hFFFF, "ones");
    chk("ones z4", dut.z[4], 160);
    chk("ones z0", dut.z[0], 16);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ones xsign%0d", k), dut.x[k][16], 0);
      chk($sformatf("ones ysign%0d", k), dut.y[k][16], 0);
      chk($sformatf("ones zsign%0d", k), dut.z[k][19], 0);
    end
    measure_pwm(hi);
    chk("pwm full", hi, exp_duty());
    chk("pwm full const", hi, 320);

    // All zeros -> -16 samples, full-scale negative
    do_reset();
    for (int s = 0; s < 5; s++) send_sample(16'h0000, "zeros");
    chk("zeros z4", dut.z[4], -160);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("zeros xsign%0d", k), dut.x[k][16], 1);
      chk($sformatf("zeros ysign%0d", k), dut.y[k][16], 1);
      chk($sformatf("zeros zsign%0d", k), dut.z[k][19], 1);
    end
    measure_pwm(hi);
    chk("pwm off", hi, 0);

    // Impulse response, then a mid-sample reset
    do_reset();
    send_sample(16'hFFFF, "impulse");
    chk("impulse z4 0", dut.z[4], z4_tab[0]);
    for (int s = 1; s < 6; s++) begin
      send_sample(16'hAAAA, "impulse");
      chk($sformatf("impulse z4 %0d", s), dut.z[4], z4_tab[s]);
    end
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst z4", dut.z[4], 0);
    chk("midrst x0", dut.x[0], 0);
    chk("midrst ampSD", ampSD, 0);
    chk("midrst micClk", micClk, 0);
    check_now("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    micData = 1'b0;
    send_sample(16'hFFFF, "postrst");
    chk("postrst z4", dut.z[4], 16);

    // Random PDM with varying density
    do_reset();
    for (int s = 0; s < 10; s++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: bits = 16'(a & b);
        1: bits = 16'(a | b);
        default: bits = 16'(a);
      endcase
      send_sample(bits, $sformatf("rand%0d", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
